// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, slow results are
// buffered in a small FIFO and written in idle slots. Also tracks pending slow destinations.
module regfile_write_arbiter #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned STARVE = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        lr_issue,
    input  logic [4:0]  lr_addr,
    input  logic        sr_valid,
    output logic        sr_ready,
    input  logic [4:0]  sr_addr,
    input  logic [31:0] sr_data,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        stall,
    output logic        wb_hold,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data,
    output logic        err
);

    localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned WaitW = $clog2(STARVE + 1);
    localparam logic [CntW-1:0]  DepthC   = CntW'(DEPTH);
    localparam logic [WaitW-1:0] WaitLimC = WaitW'(STARVE - 1);

    logic [4:0]  fifo_addr [DEPTH];
    logic [31:0] fifo_data [DEPTH];

    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             hold_q, hold_d;
    logic [31:0]      pending_q, pending_d;
    logic             err_q, err_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_addr_q, rf_addr_d;
    logic [31:0]      rf_data_q, rf_data_d;

    logic        fifo_empty;
    logic        accept;
    logic        pop;
    logic        bypass;
    logic        enq;
    logic        win_valid;
    logic [4:0]  win_addr;
    logic [31:0] win_data;

    assign fifo_empty = (count_q == '0);
    // Ready is forced low while reset is held, independent of the cleared count.
    assign sr_ready   = reset & (count_q < DepthC);
    assign accept     = sr_valid & sr_ready;
    assign pop        = ~wb_we & ~fifo_empty;
    assign bypass     = ~wb_we & fifo_empty & accept;
    assign enq        = accept & ~bypass;

    always_comb begin
        win_valid = 1'b0;
        win_addr  = '0;
        win_data  = '0;
        if (wb_we) begin
            win_valid = 1'b1;
            win_addr  = wb_addr;
            win_data  = wb_data;
        end else if (pop) begin
            win_valid = 1'b1;
            win_addr  = fifo_addr[rd_ptr_q];
            win_data  = fifo_data[rd_ptr_q];
        end else if (bypass) begin
            win_valid = 1'b1;
            win_addr  = sr_addr;
            win_data  = sr_data;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (enq) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        unique case ({enq, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        rf_we_d   = win_valid & (win_addr != 5'd0);
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (win_valid) begin
            rf_addr_d = win_addr;
            rf_data_d = win_data;
        end
    end

    // Clear on commit first so a same-cycle reservation of the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (rf_we_q) begin
            pending_d[rf_addr_q] = 1'b0;
        end
        if (lr_issue && (lr_addr != 5'd0)) begin
            pending_d[lr_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    assign err_d = err_q | (wb_we & (wb_addr != 5'd0) & pending_q[wb_addr]);

    always_comb begin
        wait_d = wait_q;
        hold_d = hold_q;
        if (fifo_empty || pop) begin
            wait_d = '0;
        end else if (wait_q != WaitLimC) begin
            wait_d = wait_q + WaitW'(1);
        end
        if (pop) begin
            hold_d = 1'b0;
        end else if (!fifo_empty && (wait_q == WaitLimC)) begin
            hold_d = 1'b1;
        end
    end

    assign stall = ((rs_addr != 5'd0) & pending_q[rs_addr]) |
                   ((rt_addr != 5'd0) & pending_q[rt_addr]) |
                   (lr_issue & (lr_addr != 5'd0) & pending_q[lr_addr]);

    always_ff @(posedge clock) begin
        if (enq) begin
            fifo_addr[wr_ptr_q] <= sr_addr;
            fifo_data[wr_ptr_q] <= sr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            wait_q    <= '0;
            hold_q    <= 1'b0;
            pending_q <= '0;
            err_q     <= 1'b0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            wait_q    <= wait_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign wb_hold = hold_q;
    assign rf_we   = rf_we_q;
    assign rf_addr = rf_addr_q;
    assign rf_data = rf_data_q;
    assign err     = err_q;

endmodule
